aes_input_masker: RTL
=====================

# aes_input_masker

Front-end share generator for the masked AES-128 encryption core. It captures a plaintext block and key, collects 256 fresh random bits from the RNG over a valid/ready handshake, and splits each operand into two Boolean shares. It then emits the shares with a one-cycle `start_o` strobe. The share-2 outputs are already in the core's `L`-bit-per-byte layout with zeroed redundant bits, so they connect directly to the core's `state_share2_i` / `key_share2_i` inputs.

## Interface
- `RNG_W`, 32 — RNG word width; legal values 8, 16, 32, 64, 128, 256.
- `REJECT_ZERO`, 1 — when 1, an all-zero RNG word is accepted (handshake completes) but discarded.

- `clk_i` in 1 — clock, active rising edge.
- `arst_n_i` in 1 — reset, asynchronous, active-low.
- `req_i` in 1 — request; sampled only in IDLE.
- `busy_o` out 1 — high in every state except IDLE.
- `data_i` in 128 — plaintext; captured on an accepted request.
- `key_i` in 128 — key; captured on an accepted request.
- `rng_data_i` in RNG_W — random word.
- `rng_valid_i` in 1 — RNG word valid.
- `rng_ready_o` out 1 — high only in COLLECT.
- `state_share1_o` out 128 — plaintext XOR state mask, standard representation.
- `key_share1_o` out 128 — key XOR key mask, standard representation.
- `state_share2_o` out 16*`L` — state mask; byte i is at [i*`L+:8], and the `RED` bits are zero.
- `key_share2_o` out 16*`L` — key mask, same layout.
- `start_o` out 1 — one-cycle strobe; shares are valid in that cycle.
- `key_destruct_i` in 1 — erases all key material and aborts any operation in progress.

## Operation
- FSM states: IDLE, COLLECT, EMIT.
- **IDLE → COLLECT**
  - Taken when `req_i` is high and `key_destruct_i` is low.
  - `data_i` and `key_i` are registered on that edge.
  - The word counter is cleared.
- **COLLECT**
  - A word is accepted on each cycle with `rng_valid_i` && `rng_ready_o`.
  - Accepted word n fills mask bits [n*RNG_W +: RNG_W] of a 256-bit mask register.
  - Bits [127:0] are the state mask; bits [255:128] are the key mask.
  - When `REJECT_ZERO`=1, a zero word does not advance the counter.
  - The FSM moves to EMIT on the edge that accepts word 256/RNG_W − 1. The counter never wraps.
- **EMIT edge** (entering EMIT):
  - share1 outputs ← captured operand XOR mask.
  - share2 outputs ← mask bytes, with zeroed `RED` bits.
- **EMIT cycle:**
  - `start_o` is high.
  - The mask and captured operands are cleared to zero.
  - The next state is IDLE.
- Share outputs hold their values until the next EMIT, `key_destruct_i`, or reset.
- **`key_destruct_i`** (any state) clears, on the next edge:
  - the captured key and the whole mask;
  - `key_share1_o` and `key_share2_o`.
- **`key_destruct_i` in COLLECT or EMIT:**
  - The FSM returns to IDLE.
  - In COLLECT, no `start_o` is produced.
  - In EMIT, `start_o` is suppressed in that cycle.
- **`key_destruct_i` and `req_i` together in IDLE:** `key_destruct_i` wins and the request is dropped.
- **`req_i` while busy:** ignored; it is not queued.
- **`rng_valid_i` outside COLLECT:** ignored, because `rng_ready_o` is low.

## Timing
- All outputs reset to 0 and the FSM resets to IDLE.
- Reset asserted mid-operation aborts immediately, with no `start_o`.
- With no RNG stalls and N = 256/RNG_W, `req_i` sampled at cycle 0 gives:
  - COLLECT during cycles 1..N;
  - `start_o` at cycle N+1 (cycle 9 for RNG_W=32);
  - IDLE at cycle N+2.
- Each RNG stall cycle or rejected zero word adds one cycle.
- Back-to-back operation: the next `req_i` can be accepted in the first IDLE cycle after EMIT.
- `busy_o` and `rng_ready_o` are decoded from registered state; neither has a combinational path from an input.

## Structure
- Shared package holds:
  - `L` and `RED` (existing defines);
  - the state encoding `MASKER_IDLE/COLLECT/EMIT`;
  - the constant `MASK_BITS`=256.
- Sub-module `mask_collector`:
  - owns the word counter, the zero-reject logic and the 256-bit shift/fill register;
  - has a `done_o` pulse and a `clear_i` input.
- The top level holds the FSM, operand capture, the XOR, and the output registers with `L` packing.

## Test plan
- **Basic masking:**
  - Stimulus: FIPS-197 key 000102…0f, plaintext 00112233…eeff, RNG_W=32, RNG words i → 0x0101_0101*(i+1).
  - `start_o` is at cycle 9.
  - `state_share1_o` = plaintext ^ {0x04040404, 0x03030303, 0x02020202, 0x01010101} (MSW first).
  - Share2 `RED` bits are 0.
  - share1 XOR share2 bytes equals plaintext and key.
- **RNG stalls:** `rng_valid_i` toggles every other cycle → `start_o` is at cycle 17; share values are identical to the previous test.
- **Zero rejection:** words 0 and 3 are 0x00000000 → both are discarded, 10 words are consumed, and `start_o` is delayed by 2 cycles.
- **Destruct:**
  - Stimulus: `key_destruct_i` pulsed in COLLECT after 5 words.
  - No `start_o`; the FSM is back in IDLE.
  - `key_share*_o` = 0; the state-share outputs hold their previous values.
  - Stimulus: destruct and `req_i` together in IDLE → the request is dropped.
- **Reset and busy request:**
  - `arst_n_i` low mid-COLLECT → all outputs are 0 asynchronously, and the next request completes normally.
  - `req_i` held high throughout → exactly one `start_o` every N+2 cycles.

Source files
------------

// File: rtl/aes_input_masker_pkg.sv
// Shared constants, state encoding and share-2 byte packing for the AES input masker.
package aes_input_masker_pkg;

    localparam int RED       = 4;
    localparam int L         = 8 + RED;
    localparam int MASK_BITS = 256;

    typedef enum logic [1:0] {
        MASKER_IDLE    = 2'd0,
        MASKER_COLLECT = 2'd1,
        MASKER_EMIT    = 2'd2
    } masker_state_e;

    typedef struct packed {
        logic [127:0] state;
        logic [127:0] key;
    } operand_t;

    // Spread 16 bytes into L-bit lanes, redundant bits held at zero.
    function automatic logic [16*L-1:0] pack_l(input logic [127:0] b);
        logic [16*L-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*L +: 8] = b[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/aes_input_masker_mask_collector.sv
// Gathers MASK_BITS of randomness from the RNG, one RNG_W word per accepted handshake.
module mask_collector
    import aes_input_masker_pkg::*;
#(
    parameter int RNG_W       = 32,
    parameter int REJECT_ZERO = 1
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [RNG_W-1:0]     rng_data_i,
    input  logic                 rng_valid_i,
    output logic [MASK_BITS-1:0] mask_o,
    output logic                 done_o
);

    localparam int N     = MASK_BITS / RNG_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [CNT_W-1:0]     cnt_q;
    logic [MASK_BITS-1:0] mask_q, mask_d;
    logic                 take, last;

    assign take = en_i && rng_valid_i && !((REJECT_ZERO != 0) && (rng_data_i == '0));
    assign last = (cnt_q == CNT_W'(N - 1));

    always_comb begin
        mask_d = mask_q;
        if (clear_i)
            mask_d = '0;
        else if (take)
            mask_d[int'(cnt_q)*RNG_W +: RNG_W] = rng_data_i;
    end

    // mask_o is the next-state view so the final word is usable on the done edge.
    assign mask_o = mask_d;
    assign done_o = take && last && !clear_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q  <= '0;
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
            if (clear_i)
                cnt_q <= '0;
            else if (take && !last)
                cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/aes_input_masker.sv
// Splits plaintext and key into two Boolean shares using fresh RNG masks.
module aes_input_masker
    import aes_input_masker_pkg::*;
#(
    parameter int RNG_W       = 32,
    parameter int REJECT_ZERO = 1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              req_i,
    output logic              busy_o,
    input  logic [127:0]      data_i,
    input  logic [127:0]      key_i,
    input  logic [RNG_W-1:0]  rng_data_i,
    input  logic              rng_valid_i,
    output logic              rng_ready_o,
    output logic [127:0]      state_share1_o,
    output logic [127:0]      key_share1_o,
    output logic [16*L-1:0]   state_share2_o,
    output logic [16*L-1:0]   key_share2_o,
    output logic              start_o,
    input  logic              key_destruct_i
);

    masker_state_e        state_q;
    operand_t             opnd_q;
    logic [MASK_BITS-1:0] mask;
    logic                 coll_clear, coll_done;

    assign busy_o      = (state_q != MASKER_IDLE);
    assign rng_ready_o = (state_q == MASKER_COLLECT);
    assign start_o     = (state_q == MASKER_EMIT) && !key_destruct_i;

    // Counter restarts on every new request; mask is wiped once consumed or on destruct.
    assign coll_clear = key_destruct_i
                     || ((state_q == MASKER_IDLE) && req_i)
                     || (state_q == MASKER_EMIT);

    mask_collector #(
        .RNG_W       (RNG_W),
        .REJECT_ZERO (REJECT_ZERO)
    ) u_collector (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .clear_i     (coll_clear),
        .en_i        (rng_ready_o),
        .rng_data_i  (rng_data_i),
        .rng_valid_i (rng_valid_i),
        .mask_o      (mask),
        .done_o      (coll_done)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q        <= MASKER_IDLE;
            opnd_q         <= '0;
            state_share1_o <= '0;
            key_share1_o   <= '0;
            state_share2_o <= '0;
            key_share2_o   <= '0;
        end else if (key_destruct_i) begin
            state_q      <= MASKER_IDLE;
            opnd_q       <= '0;
            key_share1_o <= '0;
            key_share2_o <= '0;
        end else begin
            case (state_q)
                MASKER_IDLE: begin
                    if (req_i) begin
                        opnd_q.state <= data_i;
                        opnd_q.key   <= key_i;
                        state_q      <= MASKER_COLLECT;
                    end
                end
                MASKER_COLLECT: begin
                    if (coll_done) begin
                        state_share1_o <= opnd_q.state ^ mask[127:0];
                        key_share1_o   <= opnd_q.key ^ mask[255:128];
                        state_share2_o <= pack_l(mask[127:0]);
                        key_share2_o   <= pack_l(mask[255:128]);
                        state_q        <= MASKER_EMIT;
                    end
                end
                MASKER_EMIT: begin
                    opnd_q  <= '0;
                    state_q <= MASKER_IDLE;
                end
                default: state_q <= MASKER_IDLE;
            endcase
        end
    end

endmodule
